// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, TCON bit positions and count limit shared by the timer blocks
package timer_pkg;

    localparam logic [3:0]  TH_OFF   = 4'h0;
    localparam logic [3:0]  TL_OFF   = 4'h4;
    localparam logic [3:0]  TCON_OFF = 4'h8;
    localparam logic [3:0]  PSC_OFF  = 4'hC;

    localparam int          EN_BIT   = 0;
    localparam int          IEN_BIT  = 1;
    localparam int          STAT_BIT = 2;

    localparam logic [31:0] TL_MAX   = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: PSC register and divider producing one tick per PSC+1 enabled cycles (built only with TIMER_PRESCALER_EN)
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        wr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] psc_o,
    output logic        tick_o
);

    logic [15:0] psc_q, psc_d, cnt_q, cnt_d;

    assign psc_o  = psc_q;
    assign tick_o = en_i && (cnt_q == psc_q);

    // next divider state: a PSC write restarts the count, otherwise it counts only while enabled
    always_comb begin
        psc_d = wr_i ? wdata_i : psc_q;
        cnt_d = wr_i ? 16'd0 : !en_i ? cnt_q : tick_o ? 16'd0 : cnt_q + 16'd1;
    end

    // divider flops, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q <= 16'd0;
            cnt_q <= 16'd0;
        end else begin
            psc_q <= psc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped 32-bit interval timer with level interrupt; optional prescaler under TIMER_PRESCALER_EN
module timer_irq
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [31:0] TH_RESET  = 32'hFFFF_F000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWr,
    input  logic        MemRd,
    output logic [31:0] rdata,
    output logic        irq
);

    logic        sel, tick, ovf;
    logic [3:0]  off;
    logic        wr_th, wr_tl, wr_tcon;
    logic [31:0] th_q, th_d, tl_q, tl_d, psc_rd;
    logic        en_q, en_d, ien_q, ien_d, stat_q, stat_d, irq_q, irq_d;
    logic        unused_addr;

    assign sel         = addr[31:4] == BASE_ADDR[31:4];
    assign off         = {addr[3:2], 2'b00};
    assign unused_addr = ^addr[1:0];
    assign wr_th       = MemWr && sel && off == TH_OFF;
    assign wr_tl       = MemWr && sel && off == TL_OFF;
    assign wr_tcon     = MemWr && sel && off == TCON_OFF;
    assign irq         = irq_q;

`ifdef TIMER_PRESCALER_EN
    logic [15:0] psc;

    timer_prescaler u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en_q),
        .wr_i    (MemWr && sel && off == PSC_OFF),
        .wdata_i (wdata[15:0]),
        .psc_o   (psc),
        .tick_o  (tick)
    );

    assign psc_rd = {16'd0, psc};
`else
    assign tick   = 1'b1;
    assign psc_rd = 32'd0;
`endif

    // next state: bus writes beat counting, a TL write suppresses its own overflow, hardware STAT set beats a TCON write
    always_comb begin
        ovf    = en_q && tick && tl_q == TL_MAX && !wr_tl;
        th_d   = wr_th ? wdata : th_q;
        tl_d   = wr_tl ? wdata : !(en_q && tick) ? tl_q : tl_q == TL_MAX ? th_q : tl_q + 32'd1;
        en_d   = wr_tcon ? wdata[EN_BIT]  : en_q;
        ien_d  = wr_tcon ? wdata[IEN_BIT] : ien_q;
        stat_d = (ovf && ien_q) || (wr_tcon ? wdata[STAT_BIT] : stat_q);
        irq_d  = ien_d && stat_d;
    end

    // register file and interrupt flop, reset asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= TH_RESET;
            tl_q   <= TH_RESET;
            en_q   <= 1'b0;
            ien_q  <= 1'b0;
            stat_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            en_q   <= en_d;
            ien_q  <= ien_d;
            stat_q <= stat_d;
            irq_q  <= irq_d;
        end
    end

    // combinational read port showing pre-write contents
    always_comb begin
        rdata = !(MemRd && sel) ? 32'd0 :
                off == TH_OFF   ? th_q :
                off == TL_OFF   ? tl_q :
                off == TCON_OFF ? {29'd0, stat_q, ien_q, en_q} : psc_rd;
    end

endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: directed self-checking bench for timer_irq
module tb_timer_irq;

    localparam logic [31:0] B = 32'h4000_0000;

    logic        clk = 1'b0, reset = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        MemWr = 1'b0, MemRd = 1'b0;
    logic [31:0] rdata;
    logic        irq;
    int          errors = 0, checks = 0;

    timer_irq dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .MemWr (MemWr),
        .MemRd (MemRd),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; MemWr = 1'b1;
        @(posedge clk); #1;
        MemWr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; MemRd = 1'b1;
        #1 check(tag, rdata, exp);
        MemRd = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #2 check("irq_in_reset", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        rd_chk("th_rst", B + 0, 32'hFFFF_F000);
        rd_chk("tl_rst", B + 4, 32'hFFFF_F000);
        rd_chk("tcon_rst", B + 8, 32'd0);
        check("irq_rst", {31'd0, irq}, 32'd0);

        wr(B + 0, 32'hFFFF_FFFD);
        wr(B + 4, 32'hFFFF_FFFD);
        wr(B + 8, 32'd3);
        rd_chk("tl_start", B + 4, 32'hFFFF_FFFD);
        step(); rd_chk("tl_inc1", B + 4, 32'hFFFF_FFFE);
        check("irq_pre1", {31'd0, irq}, 32'd0);
        step(); rd_chk("tl_inc2", B + 4, 32'hFFFF_FFFF);
        check("irq_pre2", {31'd0, irq}, 32'd0);
        step(); rd_chk("tl_reload", B + 4, 32'hFFFF_FFFD);
        check("irq_set", {31'd0, irq}, 32'd1);
        wr(B + 8, 32'd3);
        check("irq_clear", {31'd0, irq}, 32'd0);
        wr(B + 8, 32'd0);
        step(); step();
        rd_chk("tl_frozen", B + 4, 32'hFFFF_FFFF);

        wr(B + 8, 32'd1);
        step();
        rd_chk("tl_reload_noien", B + 4, 32'hFFFF_FFFD);
        rd_chk("tcon_noien", B + 8, 32'd1);
        check("irq_noien", {31'd0, irq}, 32'd0);
        wr(B + 8, 32'd0);

        wr(B + 4, 32'hFFFF_FFFF);
        wr(B + 8, 32'd3);
        wr(B + 4, 32'h0000_0010);
        rd_chk("tl_write_wins", B + 4, 32'h0000_0010);
        rd_chk("tcon_no_stat", B + 8, 32'd3);
        check("irq_tl_write", {31'd0, irq}, 32'd0);
        wr(B + 8, 32'd0);

        addr = B; wdata = 32'h0000_1234; MemWr = 1'b1; MemRd = 1'b1;
        #1 check("rw_pre_write", rdata, 32'hFFFF_FFFD);
        @(posedge clk); #1;
        MemWr = 1'b0;
        check("rw_post_write", rdata, 32'h0000_1234);
        MemRd = 1'b0;
        #1 check("rd_strobe_low", rdata, 32'd0);
        rd_chk("unselected", 32'h5000_0000, 32'd0);
        rd_chk("above_window", B + 32'h10, 32'd0);

        wr(B + 12, 32'd5);
`ifdef TIMER_PRESCALER_EN
        rd_chk("psc_rd", B + 12, 32'd5);
        wr(B + 12, 32'd3);
        wr(B + 4, 32'd0);
        wr(B + 8, 32'd1);
        step(); step(); step();
        rd_chk("psc_hold", B + 4, 32'd0);
        step(); rd_chk("psc_tick1", B + 4, 32'd1);
        step(); step(); step(); step();
        rd_chk("psc_tick2", B + 4, 32'd2);
        wr(B + 8, 32'd0);
        wr(B + 12, 32'd0);
`else
        rd_chk("psc_absent", B + 12, 32'd0);
`endif

        wr(B + 4, 32'hFFFF_FFFE);
        wr(B + 8, 32'd3);
        step();
        wr(B + 8, 32'd3);
        rd_chk("tcon_hw_wins", B + 8, 32'd7);
        check("irq_hw_wins", {31'd0, irq}, 32'd1);
        rd_chk("tl_new_th", B + 4, 32'h0000_1234);

        reset = 1'b0;
        #1 check("irq_async_rst", {31'd0, irq}, 32'd0);
        rd_chk("th_async_rst", B + 0, 32'hFFFF_F000);
        rd_chk("tl_async_rst", B + 4, 32'hFFFF_F000);
        rd_chk("tcon_async_rst", B + 8, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        rd_chk("tl_after_rst", B + 4, 32'hFFFF_F000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
